// File: rtl/shift_seq_ctrl_if.sv
// Command, shifter and result signals of the sequential shift front-end.
// slave  : the controller side (takes commands, drives the shifter, returns results).
// master : the environment side (issues commands, closes the shifter loop, takes results).
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [AMT_W-1:0] cmd_amt;
  logic             cmd_lr;
  logic [WIDTH-1:0] sh_in;
  logic [3:0]       sh_amt;
  logic             sh_lr;
  logic [WIDTH-1:0] sh_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_lr, sh_out, res_ready,
    output cmd_ready, sh_in, sh_amt, sh_lr, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_lr, sh_out, res_ready,
    input  cmd_ready, sh_in, sh_amt, sh_lr, res_valid, res_data, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequential front-end for the 16-bit combinational shifter. Breaks a 0..63
// shift into passes of at most MAX_STEP positions, registering the shifter
// output between passes, and returns the result on a valid/ready handshake.
module shift_seq_ctrl #(
  parameter int WIDTH    = 16,
  parameter int AMT_W    = 6,
  parameter int MAX_STEP = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(MAX_STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             lr_q, lr_d;

  logic [3:0]       chunk;
  logic [AMT_W-1:0] rem_sub;
  logic             accept;

  // Per-pass amount: a full step while more than one step remains, else the tail.
  assign chunk   = (rem_q > STEP_AMT) ? STEP_AMT[3:0] : rem_q[3:0];
  assign rem_sub = rem_q - AMT_W'(chunk);
  assign accept  = bus.cmd_valid && (state_q == S_IDLE);

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res_data  = work_q;
  assign bus.sh_in     = work_q;
  assign bus.sh_lr     = lr_q;
  assign bus.sh_amt    = (state_q == S_RUN) ? chunk : 4'd0;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      lr_q    <= lr_d;
    end
  end

  // Next-state: latch command in IDLE, fold one shifter pass per RUN cycle.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    lr_d    = lr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          work_d  = bus.cmd_data;
          rem_d   = bus.cmd_amt;
          lr_d    = bus.cmd_lr;
          state_d = (bus.cmd_amt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        work_d = bus.sh_out;
        rem_d  = rem_sub;
        if (rem_sub == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 16-bit shifter in the loop.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(16), .AMT_W(6)) bus ();

  // Stand-in for the combinational Shift_16bit: logical shift, zero fill.
  assign bus.sh_out = bus.sh_lr ? (bus.sh_in << bus.sh_amt) : (bus.sh_in >> bus.sh_amt);

  shift_seq_ctrl #(.WIDTH(16), .AMT_W(6), .MAX_STEP(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a command, check every RUN pass (chunk sequence, no early valid),
  // then check the result in DONE. Leaves the DUT in DONE.
  task automatic run_cmd(input string tag, input logic [15:0] d, input logic lr,
                         input logic [5:0] amt, input logic [15:0] exp);
    int rem;
    int ch;
    @(negedge clk);
    check({tag, " cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_lr    = lr;
    bus.cmd_amt   = amt;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    rem = amt;
    while (rem != 0) begin
      @(negedge clk);
      ch = (rem > 15) ? 15 : rem;
      check({tag, " sh_amt"}, bus.sh_amt, ch);
      check({tag, " sh_lr"}, bus.sh_lr, lr);
      check({tag, " early valid"}, bus.res_valid, 0);
      rem -= ch;
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, " res_valid"}, bus.res_valid, 1);
    check({tag, " res_data"}, bus.res_data, exp);
    check({tag, " sh_amt done"}, bus.sh_amt, 0);
    check({tag, " busy"}, bus.busy, 1);
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle busy"}, bus.busy, 0);
    check({tag, " idle cmd_ready"}, bus.cmd_ready, 1);
    check({tag, " idle res_valid"}, bus.res_valid, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_amt   = '0;
    bus.cmd_lr    = 1'b0;
    bus.res_ready = 1'b0;

    // Reset values
    #2;
    check("rst res_valid", bus.res_valid, 0);
    check("rst res_data", bus.res_data, 0);
    check("rst busy", bus.busy, 0);
    check("rst cmd_ready", bus.cmd_ready, 1);
    check("rst sh_amt", bus.sh_amt, 0);
    check("rst sh_in", bus.sh_in, 0);
    check("rst sh_lr", bus.sh_lr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd("r1", 16'hFF00, 1'b0, 6'd1, 16'h7F80);
    release_res("r1");
    run_cmd("l2", 16'hFF00, 1'b1, 6'd2, 16'hFC00);
    release_res("l2");
    run_cmd("l9", 16'h00FF, 1'b1, 6'd9, 16'hFE00);
    release_res("l9");
    run_cmd("r33", 16'h00FF, 1'b0, 6'd33, 16'h0000);
    release_res("r33");
    run_cmd("z0", 16'h1234, 1'b0, 6'd0, 16'h1234);
    release_res("z0");
    run_cmd("r16", 16'hFFFF, 1'b0, 6'd16, 16'h0000);
    release_res("r16");
    run_cmd("l15", 16'h0001, 1'b1, 6'd15, 16'h8000);
    release_res("l15");
    run_cmd("l63", 16'hFFFF, 1'b1, 6'd63, 16'h0000);
    release_res("l63");

    // Backpressure: result held, stray command ignored
    run_cmd("bp", 16'h00FF, 1'b1, 6'd4, 16'h0FF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold data", bus.res_data, 16'h0FF0);
      check("bp hold valid", bus.res_valid, 1);
      check("bp cmd_ready", bus.cmd_ready, 0);
      if (i == 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'hAAAA;
        bus.cmd_amt   = 6'd1;
        bus.cmd_lr    = 1'b0;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("bp after pulse", bus.res_data, 16'h0FF0);
    release_res("bp");
    @(negedge clk);
    check("bp no stray run", bus.busy, 0);

    // Reset during the 3rd RUN cycle of a 63-position command
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'hFFFF;
    bus.cmd_amt   = 6'd63;
    bus.cmd_lr    = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ra run busy", bus.busy, 1);
    check("ra run sh_amt", bus.sh_amt, 15);
    #2 rst_n = 1'b0;
    #1;
    check("ra busy", bus.busy, 0);
    check("ra res_valid", bus.res_valid, 0);
    check("ra res_data", bus.res_data, 0);
    check("ra sh_amt", bus.sh_amt, 0);
    check("ra sh_in", bus.sh_in, 0);
    check("ra sh_lr", bus.sh_lr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("ra no result", bus.res_valid, 0);
    end
    run_cmd("post", 16'hFF00, 1'b0, 6'd2, 16'h3FC0);
    release_res("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
